// File: rtl/rggen_rtl_pkg.sv
// Shared rggen bus types plus the AXI4-Lite bridge FSM state and status-to-resp mapping.
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_READ  = 2'b00,
    RGGEN_WRITE = 2'b01
  } rggen_access;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  typedef enum logic [1:0] {
    IDLE,
    BUS_ACCESS,
    WRITE_RESPONSE,
    READ_RESPONSE
  } rggen_axi4lite_bridge_state;

  function automatic logic [1:0] rggen_status_to_axi_resp(rggen_status status);
    case (status)
      RGGEN_OKAY:         return 2'b00;
      RGGEN_EXOKAY:       return 2'b01;
      RGGEN_SLAVE_ERROR:  return 2'b10;
      RGGEN_DECODE_ERROR: return 2'b11;
      default:            return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/rggen_bus_if.sv
// Single-request register bus between protocol front ends and the register adapter.
interface rggen_bus_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
);
  import rggen_rtl_pkg::*;

  logic                     valid;
  rggen_access              access;
  logic [ADDRESS_WIDTH-1:0] address;
  logic [BUS_WIDTH-1:0]     write_data;
  logic [BUS_WIDTH/8-1:0]   strobe;
  logic                     ready;
  rggen_status              status;
  logic [BUS_WIDTH-1:0]     read_data;

  modport master (
    output valid, access, address, write_data, strobe,
    input  ready, status, read_data
  );

  modport slave (
    input  valid, access, address, write_data, strobe,
    output ready, status, read_data
  );
endinterface

// File: rtl/rggen_axi4lite_write_joiner.sv
// Latches AW and W independently; complete is high once both are held or arrive this cycle.
// Each buffer takes one beat while accept is high and hold is low; clear empties both.
module rggen_axi4lite_write_joiner #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     accept,
  input  logic                     hold,
  input  logic                     clear,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [ADDRESS_WIDTH-1:0] awaddr,
  input  logic                     wvalid,
  output logic                     wready,
  input  logic [BUS_WIDTH-1:0]     wdata,
  input  logic [BUS_WIDTH/8-1:0]   wstrb,
  output logic                     empty,
  output logic                     complete,
  output logic [ADDRESS_WIDTH-1:0] address,
  output logic [BUS_WIDTH-1:0]     data,
  output logic [BUS_WIDTH/8-1:0]   strobe
);
  logic                     aw_full;
  logic                     w_full;
  logic [ADDRESS_WIDTH-1:0] aw_addr;
  logic [BUS_WIDTH-1:0]     w_data;
  logic [BUS_WIDTH/8-1:0]   w_strb;
  logic                     aw_take;
  logic                     w_take;

  assign awready  = accept && !aw_full && !hold;
  assign wready   = accept && !w_full && !hold;
  assign aw_take  = awvalid && awready;
  assign w_take   = wvalid && wready;
  assign empty    = !aw_full && !w_full;
  assign complete = (aw_full || aw_take) && (w_full || w_take);

  // Bypass lets a write whose last half arrives this cycle be issued on the next edge.
  assign address = aw_full ? aw_addr : awaddr;
  assign data    = w_full ? w_data : wdata;
  assign strobe  = w_full ? w_strb : wstrb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else if (clear) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
    end else begin
      if (aw_take) begin
        aw_full <= 1'b1;
        aw_addr <= awaddr;
      end
      if (w_take) begin
        w_full <= 1'b1;
        w_data <= wdata;
        w_strb <= wstrb;
      end
    end
  end
endmodule

// File: rtl/rggen_axi4lite_bridge.sv
// AXI4-Lite slave to rggen_bus_if master, one transaction outstanding; request 1 cycle after accept.
// Readies drop while busy; response held until B/R handshake. Option: RGGEN_AXI4LITE_BRIDGE_TIMEOUT_EN.
module rggen_axi4lite_bridge
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int WRITE_FIRST    = 1,
  parameter int TIMEOUT_CYCLES = 255
)(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_awvalid,
  output logic                     o_awready,
  input  logic [ADDRESS_WIDTH-1:0] i_awaddr,
  input  logic                     i_wvalid,
  output logic                     o_wready,
  input  logic [BUS_WIDTH-1:0]     i_wdata,
  input  logic [BUS_WIDTH/8-1:0]   i_wstrb,
  output logic                     o_bvalid,
  input  logic                     i_bready,
  output logic [1:0]               o_bresp,
  input  logic                     i_arvalid,
  output logic                     o_arready,
  input  logic [ADDRESS_WIDTH-1:0] i_araddr,
  output logic                     o_rvalid,
  input  logic                     i_rready,
  output logic [BUS_WIDTH-1:0]     o_rdata,
  output logic [1:0]               o_rresp,
  rggen_bus_if.master              bus_if
);
  rggen_axi4lite_bridge_state state;
  logic                     accept;
  logic                     prio_write;
  logic                     bus_valid;
  rggen_access              bus_access;
  logic [ADDRESS_WIDTH-1:0] bus_address;
  logic [BUS_WIDTH-1:0]     bus_write_data;
  logic [BUS_WIDTH/8-1:0]   bus_strobe;
  logic                     wr_empty;
  logic                     wr_complete;
  logic                     wr_hold;
  logic                     wr_clear;
  logic [ADDRESS_WIDTH-1:0] wr_address;
  logic [BUS_WIDTH-1:0]     wr_data;
  logic [BUS_WIDTH/8-1:0]   wr_strobe;
  logic                     write_grant;
  logic                     read_grant;
  logic                     timeout;

  // The arbitration loser sees ready low: a favoured read blocks both write channels
  // on an empty joiner, a favoured write blocks AR while any write beat is offered.
  assign wr_hold     = wr_empty && i_arvalid && !prio_write;
  assign o_arready   = accept && wr_empty && (!(i_awvalid || i_wvalid) || !prio_write);
  assign write_grant = accept && wr_complete;
  assign read_grant  = i_arvalid && o_arready;
  assign wr_clear    = (state == BUS_ACCESS) && (bus_access == RGGEN_WRITE) &&
                       (bus_if.ready || timeout);

  rggen_axi4lite_write_joiner #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .BUS_WIDTH     (BUS_WIDTH)
  ) u_write_joiner (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .accept   (accept),
    .hold     (wr_hold),
    .clear    (wr_clear),
    .awvalid  (i_awvalid),
    .awready  (o_awready),
    .awaddr   (i_awaddr),
    .wvalid   (i_wvalid),
    .wready   (o_wready),
    .wdata    (i_wdata),
    .wstrb    (i_wstrb),
    .empty    (wr_empty),
    .complete (wr_complete),
    .address  (wr_address),
    .data     (wr_data),
    .strobe   (wr_strobe)
  );

`ifdef RGGEN_AXI4LITE_BRIDGE_TIMEOUT_EN
  localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  logic [TIMER_WIDTH-1:0] timer;

  assign timeout = (state == BUS_ACCESS) && !bus_if.ready &&
                   (timer == TIMER_WIDTH'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      timer <= '0;
    end else if ((state != BUS_ACCESS) || bus_if.ready || timeout) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      accept         <= 1'b0;
      prio_write     <= (WRITE_FIRST != 0);
      bus_valid      <= 1'b0;
      bus_access     <= RGGEN_READ;
      bus_address    <= '0;
      bus_write_data <= '0;
      bus_strobe     <= '0;
      o_bvalid       <= 1'b0;
      o_bresp        <= 2'b00;
      o_rvalid       <= 1'b0;
      o_rresp        <= 2'b00;
      o_rdata        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write_grant) begin
            state          <= BUS_ACCESS;
            accept         <= 1'b0;
            prio_write     <= 1'b0;
            bus_valid      <= 1'b1;
            bus_access     <= RGGEN_WRITE;
            bus_address    <= wr_address;
            bus_write_data <= wr_data;
            bus_strobe     <= wr_strobe;
          end else if (read_grant) begin
            state          <= BUS_ACCESS;
            accept         <= 1'b0;
            prio_write     <= 1'b1;
            bus_valid      <= 1'b1;
            bus_access     <= RGGEN_READ;
            bus_address    <= i_araddr;
            bus_write_data <= '0;
            bus_strobe     <= '1;
          end else begin
            accept <= 1'b1;
          end
        end
        BUS_ACCESS: begin
          if (bus_if.ready) begin
            bus_valid <= 1'b0;
            if (bus_access == RGGEN_WRITE) begin
              state    <= WRITE_RESPONSE;
              o_bvalid <= 1'b1;
              o_bresp  <= rggen_status_to_axi_resp(bus_if.status);
            end else begin
              state    <= READ_RESPONSE;
              o_rvalid <= 1'b1;
              o_rresp  <= rggen_status_to_axi_resp(bus_if.status);
              o_rdata  <= bus_if.read_data;
            end
          end else if (timeout) begin
            bus_valid <= 1'b0;
            if (bus_access == RGGEN_WRITE) begin
              state    <= WRITE_RESPONSE;
              o_bvalid <= 1'b1;
              o_bresp  <= 2'b10;
            end else begin
              state    <= READ_RESPONSE;
              o_rvalid <= 1'b1;
              o_rresp  <= 2'b10;
              o_rdata  <= '0;
            end
          end
        end
        WRITE_RESPONSE: begin
          if (i_bready) begin
            state    <= IDLE;
            o_bvalid <= 1'b0;
            accept   <= 1'b1;
          end
        end
        READ_RESPONSE: begin
          if (i_rready) begin
            state    <= IDLE;
            o_rvalid <= 1'b0;
            accept   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus_if.valid      = bus_valid;
  assign bus_if.access     = bus_access;
  assign bus_if.address    = bus_address;
  assign bus_if.write_data = bus_write_data;
  assign bus_if.strobe     = bus_strobe;
endmodule

// File: tb/tb_rggen_axi4lite_bridge.sv
// Directed bench for rggen_axi4lite_bridge acting as AXI4-Lite master and rggen bus slave.
module tb_rggen_axi4lite_bridge;
  import rggen_rtl_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;
`ifdef RGGEN_AXI4LITE_BRIDGE_TIMEOUT_EN
  localparam int RD_WAIT = 3;
`else
  localparam int RD_WAIT = 5;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          awvalid = 1'b0, awready;
  logic [AW-1:0] awaddr = '0;
  logic          wvalid = 1'b0, wready;
  logic [DW-1:0] wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          bvalid, bready = 1'b0;
  logic [1:0]    bresp;
  logic          arvalid = 1'b0, arready;
  logic [AW-1:0] araddr = '0;
  logic          rvalid, rready = 1'b0;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  int            errors = 0;
  int            checks = 0;

  rggen_bus_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(DW)) bus ();

  rggen_axi4lite_bridge #(
    .ADDRESS_WIDTH (AW),
    .BUS_WIDTH     (DW),
    .WRITE_FIRST   (1),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_awvalid (awvalid),
    .o_awready (awready),
    .i_awaddr  (awaddr),
    .i_wvalid  (wvalid),
    .o_wready  (wready),
    .i_wdata   (wdata),
    .i_wstrb   (wstrb),
    .o_bvalid  (bvalid),
    .i_bready  (bready),
    .o_bresp   (bresp),
    .i_arvalid (arvalid),
    .o_arready (arready),
    .i_araddr  (araddr),
    .o_rvalid  (rvalid),
    .i_rready  (rready),
    .o_rdata   (rdata),
    .o_rresp   (rresp),
    .bus_if    (bus)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    rst_n = 1'b0;
    bus.ready = 1'b0; bus.status = RGGEN_OKAY; bus.read_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({awready, wready, arready} !== 3'b000) begin errors++; $display("FAIL reset_readies: got %b want 000", {awready, wready, arready}); end
    checks++; if ({bvalid, rvalid, bus.valid} !== 3'b000) begin errors++; $display("FAIL reset_valids: got %b want 000", {bvalid, rvalid, bus.valid}); end
    checks++; if ({bresp, rresp, rdata} !== 36'h0) begin errors++; $display("FAIL reset_resp: got %h want 0", {bresp, rresp, rdata}); end
    checks++; if ({bus.access, bus.address, bus.write_data, bus.strobe} !== 46'h0) begin errors++; $display("FAIL reset_request: got %h want 0", {bus.access, bus.address, bus.write_data, bus.strobe}); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if ({awready, wready, arready} !== 3'b111) begin errors++; $display("FAIL idle_readies: got %b want 111", {awready, wready, arready}); end
  endtask

  task automatic test_arbitration;
    logic [9:0] seen [4];
    logic [9:0] want [4];
    int n = 0;
    want[0] = {RGGEN_WRITE, 8'h30}; want[1] = {RGGEN_READ, 8'h40};
    want[2] = {RGGEN_WRITE, 8'h34}; want[3] = {RGGEN_READ, 8'h44};
    for (int k = 0; k < 4; k++) seen[k] = 'x;
    bus.ready = 1'b1; bus.status = RGGEN_OKAY; bus.read_data = 32'h0;
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    fork
      begin
        for (int k = 0; k < 2; k++) begin
          awaddr = 8'h30 + 8'(4 * k); wdata = 32'hA0A0_0000 + 32'(k); wstrb = 4'hF;
          awvalid = 1'b1; wvalid = 1'b1;
          for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (awready && wready) break;
          end
          @(posedge clk); #1;
          awvalid = 1'b0; wvalid = 1'b0;
        end
      end
      begin
        for (int k = 0; k < 2; k++) begin
          araddr = 8'h40 + 8'(4 * k); arvalid = 1'b1;
          for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (arready) break;
          end
          @(posedge clk); #1;
          arvalid = 1'b0;
        end
      end
      begin
        for (int c = 0; c < 30; c++) begin
          @(negedge clk);
          if (bus.valid) begin
            if (n < 4) seen[n] = {bus.access, bus.address};
            n++;
          end
        end
      end
    join
    bus.ready = 1'b0; bready = 1'b0; rready = 1'b0;
    checks++; if (n !== 4) begin errors++; $display("FAIL arb_count: got %0d requests want 4", n); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (seen[k] !== want[k]) begin errors++; $display("FAIL arb_order[%0d]: got %h want %h", k, seen[k], want[k]); end
    end
  endtask

  task automatic test_single_write;
    @(posedge clk); #1;
    awaddr = 8'h10; awvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    bus.ready = 1'b1; bus.status = RGGEN_OKAY;
    @(negedge clk);
    checks++; if ({awready, wready} !== 2'b11) begin errors++; $display("FAIL sw_accept: got %b want 11", {awready, wready}); end
    @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    checks++; if ({bus.valid, bus.access, bus.address, bus.write_data, bus.strobe} !== {1'b1, RGGEN_WRITE, 8'h10, 32'hDEADBEEF, 4'hF})
      begin errors++; $display("FAIL sw_request: got %h want %h", {bus.valid, bus.access, bus.address, bus.write_data, bus.strobe}, {1'b1, RGGEN_WRITE, 8'h10, 32'hDEADBEEF, 4'hF}); end
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL sw_early_bvalid: got %b want 0", bvalid); end
    @(posedge clk); #1 bus.ready = 1'b0;
    @(negedge clk);
    checks++; if ({bvalid, bresp, bus.valid} !== 4'b1000) begin errors++; $display("FAIL sw_response: got %b want 1000", {bvalid, bresp, bus.valid}); end
    bready = 1'b1;
    @(posedge clk); #1 bready = 1'b0;
    @(negedge clk);
    checks++; if ({bvalid, awready, wready} !== 3'b011) begin errors++; $display("FAIL sw_release: got %b want 011", {bvalid, awready, wready}); end
  endtask

  task automatic test_read_error;
    @(posedge clk); #1;
    araddr = 8'h20; arvalid = 1'b1;
    @(negedge clk);
    checks++; if (arready !== 1'b1) begin errors++; $display("FAIL rd_accept: got %b want 1", arready); end
    @(posedge clk); #1 arvalid = 1'b0;
    for (int c = 0; c < RD_WAIT; c++) begin
      @(negedge clk);
      checks++; if ({bus.valid, bus.access, bus.address, bus.write_data, bus.strobe} !== {1'b1, RGGEN_READ, 8'h20, 32'h0, 4'hF})
        begin errors++; $display("FAIL rd_hold[%0d]: got %h want %h", c, {bus.valid, bus.access, bus.address, bus.write_data, bus.strobe}, {1'b1, RGGEN_READ, 8'h20, 32'h0, 4'hF}); end
    end
    @(posedge clk); #1;
    bus.ready = 1'b1; bus.status = RGGEN_SLAVE_ERROR; bus.read_data = 32'h1234;
    @(posedge clk); #1;
    bus.ready = 1'b0; bus.status = RGGEN_OKAY; bus.read_data = 32'h0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if ({rvalid, rresp, rdata, bus.valid} !== {1'b1, 2'b10, 32'h1234, 1'b0})
        begin errors++; $display("FAIL rd_resp_hold[%0d]: got %h want %h", c, {rvalid, rresp, rdata, bus.valid}, {1'b1, 2'b10, 32'h1234, 1'b0}); end
      @(posedge clk); #1;
    end
    rready = 1'b1;
    @(posedge clk); #1 rready = 1'b0;
    @(negedge clk);
    checks++; if ({rvalid, arready} !== 2'b01) begin errors++; $display("FAIL rd_release: got %b want 01", {rvalid, arready}); end
  endtask

  task automatic test_split_write;
    @(posedge clk); #1;
    wdata = 32'hCAFEF00D; wstrb = 4'h3; wvalid = 1'b1;
    bus.ready = 1'b1; bus.status = RGGEN_EXOKAY;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin awaddr = 8'h44; awvalid = 1'b1; end
      @(negedge clk);
      checks++; if ({arready, bus.valid, wready} !== {2'b00, c == 0})
        begin errors++; $display("FAIL split_wait[%0d]: got %b want %b", c, {arready, bus.valid, wready}, {2'b00, c == 0}); end
      @(posedge clk); #1;
      wvalid = 1'b0;
    end
    awvalid = 1'b0;
    @(negedge clk);
    checks++; if ({bus.valid, bus.access, bus.address, bus.write_data, bus.strobe} !== {1'b1, RGGEN_WRITE, 8'h44, 32'hCAFEF00D, 4'h3})
      begin errors++; $display("FAIL split_request: got %h want %h", {bus.valid, bus.access, bus.address, bus.write_data, bus.strobe}, {1'b1, RGGEN_WRITE, 8'h44, 32'hCAFEF00D, 4'h3}); end
    @(posedge clk); #1 bus.ready = 1'b0;
    @(negedge clk);
    checks++; if ({bvalid, bresp} !== 3'b101) begin errors++; $display("FAIL split_bresp: got %b want 101", {bvalid, bresp}); end
    bready = 1'b1;
    @(posedge clk); #1 bready = 1'b0;
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    awaddr = 8'h50; awvalid = 1'b1; wdata = 32'h11111111; wstrb = 4'hF; wvalid = 1'b1;
    bus.ready = 1'b0; bus.status = RGGEN_OKAY;
    @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL rm_busy: got %b want 1", bus.valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bus.valid, bvalid, rvalid, awready, wready, arready} !== 6'b0)
      begin errors++; $display("FAIL rm_async_clear: got %b want 000000", {bus.valid, bvalid, rvalid, awready, wready, arready}); end
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    awaddr = 8'h58; awvalid = 1'b1; wdata = 32'h5A5AA5A5; wstrb = 4'hC; wvalid = 1'b1; bus.ready = 1'b1;
    @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    checks++; if ({bus.valid, bus.access, bus.address, bus.write_data, bus.strobe} !== {1'b1, RGGEN_WRITE, 8'h58, 32'h5A5AA5A5, 4'hC})
      begin errors++; $display("FAIL rm_fresh_request: got %h want %h", {bus.valid, bus.access, bus.address, bus.write_data, bus.strobe}, {1'b1, RGGEN_WRITE, 8'h58, 32'h5A5AA5A5, 4'hC}); end
    @(posedge clk); #1 bus.ready = 1'b0;
    @(negedge clk);
    checks++; if ({bvalid, bresp} !== 3'b100) begin errors++; $display("FAIL rm_fresh_bresp: got %b want 100", {bvalid, bresp}); end
    bready = 1'b1;
    @(posedge clk); #1 bready = 1'b0;
  endtask

`ifdef RGGEN_AXI4LITE_BRIDGE_TIMEOUT_EN
  task automatic test_timeout;
    int cnt;
    @(posedge clk); #1;
    awaddr = 8'h60; awvalid = 1'b1; wdata = 32'h0F0F0F0F; wstrb = 4'hF; wvalid = 1'b1; bus.ready = 1'b0;
    @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.valid) cnt++; else break;
    end
    checks++; if (cnt !== 4) begin errors++; $display("FAIL to_write_cycles: got %0d want 4", cnt); end
    checks++; if ({bvalid, bresp} !== 3'b110) begin errors++; $display("FAIL to_bresp: got %b want 110", {bvalid, bresp}); end
    bready = 1'b1;
    @(posedge clk); #1 bready = 1'b0;
    araddr = 8'h64; arvalid = 1'b1; bus.read_data = 32'hFFFF0000;
    @(posedge clk); #1 arvalid = 1'b0;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.valid) cnt++; else break;
    end
    checks++; if (cnt !== 4) begin errors++; $display("FAIL to_read_cycles: got %0d want 4", cnt); end
    checks++; if ({rvalid, rresp, rdata} !== {1'b1, 2'b10, 32'h0}) begin errors++; $display("FAIL to_rresp: got %h want %h", {rvalid, rresp, rdata}, {1'b1, 2'b10, 32'h0}); end
    rready = 1'b1;
    @(posedge clk); #1 rready = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_arbitration;
    test_single_write;
    test_read_error;
    test_split_write;
    test_reset_mid;
`ifdef RGGEN_AXI4LITE_BRIDGE_TIMEOUT_EN
    test_timeout;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not reach the summary within 100000 time units");
    $fatal(1, "watchdog expired");
  end
endmodule
